imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Writer side of the instruction-memory interface: the core only fetches from i_mem; this block fills it.
//   Accepts a byte stream (valid/ready) carrying a 2-byte big-endian word count and then instruction words.
//   Assembles big-endian 32-bit words and drives the i_mem write port.
//   Holds the MIPS core in reset until the image is fully written.
// PARAMETERS
//   WORD_COUNT      256   capacity of i_mem in 32-bit words; max legal header length
//   TIMEOUT_CYCLES  1024  cycles without an accepted byte (after load_start) before error
// PORTS
//   clock       in   1   system clock; all state updates on rising edge
//   reset       in   1   synchronous, active-high; sampled on rising edge of clock
//   load_start  in   1   1-cycle pulse: begin a load (honoured in IDLE/DONE/ERR only)
//   byte_in     in   8   stream data byte
//   byte_valid  in   1   byte_in valid
//   byte_ready  out  1   loader can accept; transfer = byte_valid & byte_ready at rising edge
//   imem_we     out  1   i_mem write enable, 1-cycle pulse per word
//   imem_addr   out  32  byte address of word being written (word index << 2)
//   imem_wdata  out  32  assembled instruction word
//   core_reset  out  1   reset for MIPS_Monociclo; 1 in every state except DONE
//   busy        out  1   1 in HDR0/HDR1/DATA/WRITE
//   done        out  1   1 in DONE
//   error       out  1   1 in ERR
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0,
//     core_reset=1, busy=0, done=0, error=0; word index, byte index, length, timeout counter cleared.
//   - States: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR.
//   - IDLE/DONE/ERR + load_start -> HDR0; clears counters and error/done; core_reset=1 from next cycle.
//     load_start ignored in HDR0..WRITE.
//   - byte_ready=1 only in HDR0, HDR1, DATA; 0 in WRITE and all other states.
//   - HDR0: accepted byte -> length[15:8] -> HDR1. HDR1: byte -> length[7:0];
//     length==0 or length>WORD_COUNT -> ERR, else -> DATA.
//   - DATA: byte index 0..3; byte0 -> wdata[31:24] ... byte3 -> wdata[7:0]; on byte3 accept -> WRITE.
//   - WRITE (exactly 1 cycle): imem_we=1, imem_addr={word_idx,2'b00}, imem_wdata=word;
//     word_idx+1==length -> DONE, else -> DATA with byte index 0.
//   - Latency: last byte accepted at edge t -> imem_we high cycle t+1 -> done=1, core_reset=0 at t+2.
//   - Byte presented during WRITE is not consumed; stays pending until DATA raises byte_ready.
//   - Timeout counter: in HDR0/HDR1/DATA, increments each cycle without transfer, clears on transfer;
//     reaching TIMEOUT_CYCLES -> ERR. Partial word discarded, no write.
//   - ERR: error=1, core_reset=1, holds until load_start or reset. Words already written remain in i_mem.
//   - DONE: done=1, core_reset=0, holds until load_start or reset.
//   - reset mid-operation: immediate return to IDLE, no further imem_we, partial word dropped;
//     next load restarts at address 0.
//   - length is 16-bit; word_idx width clog2(WORD_COUNT)+1, never wraps (bounded by length check).
// TESTING
//   1. reset, load_start, stream 00 02 20 08 00 05 01 09 50 20 -> writes (0x0,0x20080005),(0x4,0x01095020); done=1, core_reset=0 2 cycles after last byte.
//   2. header 00 00 -> error=1 cycle after 2nd header byte; no imem_we; core_reset stays 1.
//   3. header 01 01 (257), WORD_COUNT=256 -> error=1; no imem_we.
//   4. byte_valid held high continuously, 2 words -> byte_ready low exactly 1 cycle per WRITE; 5th byte taken the cycle after first WRITE; no byte lost/duplicated.
//   5. TIMEOUT_CYCLES=16: header 00 01 + 2 data bytes then stall -> error=1 after 16 idle cycles; no write.
//   6. reset after 6 of 8 data bytes (len 2) -> 1 write (addr 0) only; IDLE; new load_start rewrites from addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: fills the instruction memory from a byte stream and holds the core in reset until
// the whole image has been written.
//
// The stream carries a 2-byte big-endian word count followed by the instruction words, each sent
// big-endian (most significant byte first). Every assembled word is written to i_mem with a
// one-cycle write-enable pulse at byte address word_index * 4.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   load_start  in   one-cycle pulse starting a load (only honoured in IDLE/DONE/ERR)
//   byte_in     in   [7:0] stream byte
//   byte_valid  in   byte_in is valid
//   byte_ready  out  loader accepts a byte this cycle
//   imem_we     out  i_mem write enable, one-cycle pulse per word
//   imem_addr   out  [31:0] byte address of the word being written
//   imem_wdata  out  [31:0] assembled instruction word
//   core_reset  out  reset for the core; low only once the image is complete
//   busy        out  a load is in progress
//   done        out  image fully written
//   error       out  bad header or stream timeout
module imem_loader #(
  parameter int unsigned WORD_COUNT     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned IdxW = $clog2(WORD_COUNT) + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHdr0  = 3'd1;
  localparam logic [2:0] StHdr1  = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StErr   = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [15:0]     length_q, length_d;
  logic [IdxW-1:0] word_idx_q, word_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [23:0]     word_q, word_d;   // first three bytes of the word being assembled
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [31:0]     addr_d, wdata_d;

  logic        transfer;
  logic        accepting;
  logic [15:0] hdr_len;
  logic [15:0] next_idx;

  // byte_ready is registered from the next state, so it already means "accepting" this cycle.
  assign transfer  = byte_valid & byte_ready;
  assign accepting = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StData);
  assign hdr_len   = {length_q[15:8], byte_in};
  assign next_idx  = 16'(word_idx_q) + 16'd1;

  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    tmo_d      = tmo_q;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (load_start) begin
          state_d    = StHdr0;
          length_d   = 16'd0;
          word_idx_d = '0;
          byte_idx_d = 2'd0;
          word_d     = 24'd0;
          tmo_d      = '0;
        end
      end
      StHdr0: begin
        if (transfer) begin
          length_d[15:8] = byte_in;
          state_d        = StHdr1;
        end
      end
      StHdr1: begin
        if (transfer) begin
          length_d[7:0] = byte_in;
          if (hdr_len == 16'd0 || {16'd0, hdr_len} > WORD_COUNT) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (transfer) begin
          word_d     = {word_q[15:0], byte_in};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wdata_d = {word_q, byte_in};
            addr_d  = {{(30 - IdxW){1'b0}}, word_idx_q, 2'b00};
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        word_idx_d = word_idx_q + 1'b1;
        byte_idx_d = 2'd0;
        state_d    = (next_idx == length_q) ? StDone : StData;
      end
      default: state_d = StIdle;
    endcase

    // Stall watchdog: only counts while the loader is waiting on the stream.
    if (accepting) begin
      if (transfer) begin
        tmo_d = '0;
      end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        tmo_d   = '0;
        state_d = StErr;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else if (state_q == StWrite) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      length_q   <= 16'd0;
      word_idx_q <= '0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'd0;
      tmo_q      <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wdata <= 32'd0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      length_q   <= length_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      tmo_q      <= tmo_d;
      byte_ready <= (state_d == StHdr0) || (state_d == StHdr1) || (state_d == StData);
      imem_we    <= (state_d == StWrite);
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      core_reset <= (state_d != StDone);
      busy       <= (state_d == StHdr0) || (state_d == StHdr1) || (state_d == StData) ||
                    (state_d == StWrite);
      done       <= (state_d == StDone);
      error      <= (state_d == StErr);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(
    .WORD_COUNT    (256),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .load_start(load_start),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_reset(core_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nwrites = 0;
  int rdy_low = 0;
  bit count_en = 1'b0;
  logic [63:0] exp_q[$];  // {addr, data} of expected i_mem writes
  int tcyc[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Scoreboard monitor: every write the DUT issues is matched against the queue.
  initial forever begin
    @(negedge clock);
    if (count_en && busy && !byte_ready) rdy_low++;
    if (imem_we === 1'b1) begin
      logic [63:0] e;
      nwrites++;
      check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", imem_addr, e[63:32]);
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  // Present one byte and wait (bounded) for it to be accepted; returns the accepting edge.
  task automatic send_byte(input logic [7:0] b, output int at);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    at = -1;
    while (n < 40) begin
      if (byte_ready) begin
        step();
        at = cyc;
        break;
      end
      step();
      n++;
    end
    byte_valid = 1'b0;
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: byte 0x%0h not accepted within 40 cycles", b);
    end
  endtask

  task automatic send_stream(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], tcyc[i]);
  endtask

  initial begin
    int w0;
    int t;
    reset      = 1'b1;
    load_start = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_flags", {29'd0, busy, done, error}, 32'd0);

    // 1: two-word image
    exp_q.push_back({32'h0, 32'h20080005});
    exp_q.push_back({32'h4, 32'h01095020});
    start_load();
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_stream('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20});
    check("t1_we_after_last", {31'd0, imem_we}, 32'd1);
    check("t1_done_early", {31'd0, done}, 32'd0);
    check("t1_core_reset_early", {31'd0, core_reset}, 32'd1);
    step();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_core_reset", {31'd0, core_reset}, 32'd0);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_writes", nwrites, 2);

    // 2: zero-length header
    w0 = nwrites;
    start_load();
    check("t2_core_reset_load", {31'd0, core_reset}, 32'd1);
    send_stream('{8'h00, 8'h00});
    check("t2_error", {31'd0, error}, 32'd1);
    check("t2_core_reset", {31'd0, core_reset}, 32'd1);
    step();
    check("t2_no_write", nwrites, w0);

    // 3: length 257 exceeds capacity
    start_load();
    check("t3_error_cleared", {31'd0, error}, 32'd0);
    send_stream('{8'h01, 8'h01});
    check("t3_error", {31'd0, error}, 32'd1);
    step();
    check("t3_no_write", nwrites, w0);

    // 4: valid held continuously across writes
    exp_q.push_back({32'h0, 32'hAABBCCDD});
    exp_q.push_back({32'h4, 32'h11223344});
    start_load();
    rdy_low  = 0;
    count_en = 1'b1;
    send_stream('{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44});
    step();
    count_en = 1'b0;
    check("t4_gap_word0", tcyc[5] - tcyc[2], 3);
    check("t4_gap_write", tcyc[6] - tcyc[5], 2);
    check("t4_gap_word1", tcyc[9] - tcyc[6], 3);
    check("t4_ready_low_cycles", rdy_low, 2);
    check("t4_done", {31'd0, done}, 32'd1);

    // 5: stall mid-word triggers the watchdog
    w0 = nwrites;
    start_load();
    send_stream('{8'h00, 8'h01, 8'h12, 8'h34});
    t = 0;
    while (t < 40 && error !== 1'b1) begin
      step();
      t++;
    end
    check("t5_timeout_cycles", t, 16);
    check("t5_core_reset", {31'd0, core_reset}, 32'd1);
    check("t5_no_write", nwrites, w0);

    // 6: reset after 6 of 8 data bytes
    w0 = nwrites;
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    start_load();
    send_stream('{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55, 8'h66});
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_idle_ready", {31'd0, byte_ready}, 32'd0);
    check("t6_idle_flags", {28'd0, core_reset, busy, done, error}, 32'h8);
    check("t6_one_write", nwrites - w0, 1);
    repeat (20) step();
    check("t6_no_late_write", nwrites - w0, 1);
    exp_q.push_back({32'h0, 32'hCAFEF00D});
    start_load();
    send_stream('{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D});
    step();
    check("t6_reload_done", {31'd0, done}, 32'd1);
    check("t6_total_writes", nwrites - w0, 2);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
